sample_sync: RTL

SAMPLE_SYNC -- requirements
Module: sample_sync

---
 rtl/sample_sync_pkg.sv | 27 ++
 rtl/sync_bit.sv | 34 +++
 rtl/sample_sync.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sample_sync_pkg.sv
// sample_sync_pkg
//   Shared types and constants for the sample_sync flag-synchronised capture
//   block: FSM state encoding, MODE selector values, parameter defaults and
//   internal counter widths.
package sample_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam int MODE_LEVEL  = 0;
    localparam int MODE_TOGGLE = 1;

    localparam int NCH_DEFAULT         = 3;
    localparam int W_DEFAULT           = 12;
    localparam int SYNC_STAGES_DEFAULT = 3;
    localparam int SETTLE_DEFAULT      = 2;
    localparam int MODE_DEFAULT        = MODE_LEVEL;
    localparam int RST_HOLD_DEFAULT    = 64;

    // SETTLE is limited to 0..15 and RST_HOLD to 1..1023.
    localparam int SETTLE_CNT_W = 4;
    localparam int HOLD_CNT_W   = 10;

endpackage

// File: rtl/sync_bit.sv
// sync_bit
//   Multi-flop synchronizer for a single asynchronous bit.
//   Ports:
//     clk    in   destination clock
//     rst_n  in   asynchronous active-low reset, clears the whole chain
//     d      in   asynchronous input bit
//     q      out  synchronized bit, DEPTH edges after d is first sampled
module sync_bit #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain_q;
    logic [DEPTH-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/sample_sync.sv
// sample_sync
//   Captures a multi-channel bus from a foreign clock domain when that domain
//   raises (or toggles) a completion flag. The flag is synchronized, an
//   optional settle delay lets the bus become stable, then the bus is
//   registered. Also produces a stretched active-low reset for the foreign
//   domain.
//
//   State table:
//     state      | meaning
//     -----------+-------------------------------------------------------
//     ST_IDLE    | waiting for a flag event
//     ST_SETTLE  | event accepted, counting down bus settle cycles
//     ST_CAPTURE | data_out just loaded, sample_valid high for this cycle
//
//   Ports:
//     clk_50        in   sole clock
//     reset         in   asynchronous active-low reset
//     round_done    in   asynchronous completion flag from foreign domain
//     data_in       in   NCH*W foreign bus, channel k at [k*W +: W]
//     freeze        in   suppresses new captures (events become drops)
//     clr_drop      in   clears the sticky drop flag
//     data_out      out  last captured bus value
//     sample_valid  out  one-cycle pulse coincident with data_out update
//     sample_cnt    out  capture count, wraps at 16 bits
//     drop          out  sticky: a flag event was lost
//     reset1        out  active-low reset held RST_HOLD cycles past release
module sample_sync
    import sample_sync_pkg::*;
#(
    parameter int NCH         = NCH_DEFAULT,
    parameter int W           = W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int SETTLE      = SETTLE_DEFAULT,
    parameter int MODE        = MODE_DEFAULT,
    parameter int RST_HOLD    = RST_HOLD_DEFAULT
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             round_done,
    input  logic [NCH*W-1:0] data_in,
    input  logic             freeze,
    input  logic             clr_drop,
    output logic [NCH*W-1:0] data_out,
    output logic             sample_valid,
    output logic [15:0]      sample_cnt,
    output logic             drop,
    output logic             reset1
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD =
        (SETTLE > 0) ? SETTLE_CNT_W'(SETTLE - 1) : '0;
    localparam logic [HOLD_CNT_W-1:0] HOLD_TC = HOLD_CNT_W'(RST_HOLD);

    logic                    flag_sync;
    logic                    flag_dly_q,     flag_dly_d;
    logic                    flag_event;
    state_e                  state_q,        state_d;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q,   settle_cnt_d;
    logic [NCH*W-1:0]        data_out_q,     data_out_d;
    logic                    sample_valid_q, sample_valid_d;
    logic [15:0]             sample_cnt_q,   sample_cnt_d;
    logic                    drop_q,         drop_d;
    logic [HOLD_CNT_W-1:0]   hold_cnt_q,     hold_cnt_d;
    logic                    reset1_q,       reset1_d;
    logic                    capture_go;
    logic                    event_lost;

    sync_bit #(
        .DEPTH (SYNC_STAGES)
    ) u_sync_flag (
        .clk   (clk_50),
        .rst_n (reset),
        .d     (round_done),
        .q     (flag_sync)
    );

    // Reset clears the delay flop, so a flag already high at release is seen
    // as a fresh rising edge.
    always_comb begin
        flag_dly_d = flag_sync;
        if (MODE == MODE_TOGGLE) begin
            flag_event = flag_sync ^ flag_dly_q;
        end else begin
            flag_event = flag_sync & ~flag_dly_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        event_lost   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flag_event) begin
                    if (freeze) begin
                        event_lost = 1'b1;
                    end else if (SETTLE == 0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                // freeze is deliberately ignored here: an accepted event
                // always completes.
                event_lost = flag_event;
                if (settle_cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                event_lost = flag_event;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The capture registers load on the edge that enters ST_CAPTURE, so the
    // new data and the valid pulse are visible for exactly the CAPTURE cycle.
    always_comb begin
        capture_go     = (state_d == ST_CAPTURE);
        data_out_d     = capture_go ? data_in : data_out_q;
        sample_valid_d = capture_go;
        sample_cnt_d   = capture_go ? (sample_cnt_q + 16'd1) : sample_cnt_q;
        if (event_lost) begin
            drop_d = 1'b1;
        end else if (clr_drop) begin
            drop_d = 1'b0;
        end else begin
            drop_d = drop_q;
        end
    end

    always_comb begin
        hold_cnt_d = (hold_cnt_q == HOLD_TC) ? hold_cnt_q : (hold_cnt_q + 1'b1);
        reset1_d   = (hold_cnt_d == HOLD_TC);
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            flag_dly_q     <= 1'b0;
            state_q        <= ST_IDLE;
            settle_cnt_q   <= '0;
            data_out_q     <= '0;
            sample_valid_q <= 1'b0;
            sample_cnt_q   <= '0;
            drop_q         <= 1'b0;
            hold_cnt_q     <= '0;
            reset1_q       <= 1'b0;
        end else begin
            flag_dly_q     <= flag_dly_d;
            state_q        <= state_d;
            settle_cnt_q   <= settle_cnt_d;
            data_out_q     <= data_out_d;
            sample_valid_q <= sample_valid_d;
            sample_cnt_q   <= sample_cnt_d;
            drop_q         <= drop_d;
            hold_cnt_q     <= hold_cnt_d;
            reset1_q       <= reset1_d;
        end
    end

    assign data_out     = data_out_q;
    assign sample_valid = sample_valid_q;
    assign sample_cnt   = sample_cnt_q;
    assign drop         = drop_q;
    assign reset1       = reset1_q;

endmodule
